// File: rtl/cache_fill_fsm.sv
// Cache block fill engine: on a miss, streams WORDS back-to-back memory reads
// and writes the in-order responses into the data array, then the tag array.
module cache_fill_fsm #(
   parameter int ADDR_W = 16,
   parameter int WORDS  = 8,
   parameter int OFF_W  = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              miss_detected,
   input  logic [ADDR_W-1:0] miss_address,
   output logic              fsm_busy,
   output logic              memory_read,
   output logic [ADDR_W-1:0] memory_address,
   input  logic              memory_data_valid,
   input  logic [15:0]       memory_data,
   output logic              write_data_array,
   output logic [OFF_W-1:0]  fill_word,
   output logic [15:0]       fill_data,
   output logic              write_tag_array,
   output logic [ADDR_W-1:0] fill_address
);

   localparam logic [OFF_W:0]    WORDS_C   = (OFF_W+1)'(WORDS);
   localparam logic [OFF_W:0]    LAST_C    = (OFF_W+1)'(WORDS-1);
   localparam logic [ADDR_W-1:0] BLK_MASK  = ~ADDR_W'(2*WORDS-1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t            state, state_nxt;
   logic [OFF_W:0]    req_cnt, rsp_cnt;
   logic [ADDR_W-1:0] base;

   // state register plus the request/response counters and latched block base
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         req_cnt <= '0;
         rsp_cnt <= '0;
         base    <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE) begin
            if (miss_detected) begin
               base    <= miss_address & BLK_MASK;
               req_cnt <= '0;
               rsp_cnt <= '0;
            end
         end else begin
            if (req_cnt < WORDS_C) req_cnt <= req_cnt + 1'b1;
            if (write_data_array)  rsp_cnt <= rsp_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (miss_detected)   state_nxt = BUSY;
         BUSY: if (write_tag_array) state_nxt = IDLE;
         default:                   state_nxt = IDLE;
      endcase
   end

   // Request side depends only on registers; the write strobes follow the
   // memory response combinationally, word index taken from arrival order.
   always_comb begin
      fsm_busy         = (state == BUSY);
      memory_read      = fsm_busy && (req_cnt < WORDS_C);
      memory_address   = memory_read ? base + ADDR_W'({req_cnt, 1'b0}) : '0;
      write_data_array = fsm_busy && memory_data_valid && (rsp_cnt < WORDS_C);
      write_tag_array  = write_data_array && (rsp_cnt == LAST_C);
      fill_word        = write_data_array ? rsp_cnt[OFF_W-1:0] : '0;
      fill_data        = memory_data;
      fill_address     = base;
   end

endmodule
